// File: rtl/id_operand_unit_pkg.sv
// -----------------------------------------------------------------------------
// id_operand_unit_pkg
// Shared definitions for the decode-stage operand resolution unit:
//   - default word / register-index widths used by the unit and its interface
//   - scoreboard counter width, sized for the largest allowed load latency (7)
//   - operand source selector used by the forwarding mux
//   - scoreboard counter step helper
// No ports (package).
// -----------------------------------------------------------------------------
package id_operand_unit_pkg;

    localparam int WORD_W_DEF    = 32;
    localparam int REG_IDX_W_DEF = 5;
    localparam int NUM_RD_DEF    = 2;
    localparam int NUM_FWD_DEF   = 3;
    localparam int LOAD_LAT_DEF  = 1;

    // Three bits hold any load latency from 1 to 7.
    localparam int SB_CNT_W     = 3;
    localparam int LOAD_LAT_MAX = (1 << SB_CNT_W) - 1;

    typedef enum logic [1:0] {
        OP_ZERO = 2'd0,
        OP_FWD  = 2'd1,
        OP_RF   = 2'd2
    } op_src_e;

    // Counters saturate at zero: an idle register stays idle.
    function automatic logic [SB_CNT_W-1:0] sb_next(input logic [SB_CNT_W-1:0] cnt);
        return (cnt == '0) ? '0 : cnt - 1'b1;
    endfunction

endpackage

// File: rtl/id_operand_unit_if.sv
// -----------------------------------------------------------------------------
// id_operand_unit_if
// Bundles the decode-side request (source operands, register-file data,
// forwarding buses, load information) and the execute-side response
// (stall, registered operands) of id_operand_unit.
//   master : decode/pipeline side, drives i_* and observes o_*
//   slave  : id_operand_unit, consumes i_* and drives o_*
// Signals:
//   i_valid, i_rd_en[NUM_RD], i_rd_reg[NUM_RD*REG_IDX_W], i_rf_data[NUM_RD*WORD_W]
//   i_fwd_valid[NUM_FWD], i_fwd_reg[NUM_FWD*REG_IDX_W], i_fwd_data[NUM_FWD*WORD_W]
//   i_is_load, i_dest_reg[REG_IDX_W]
//   o_stall, o_valid, o_data[NUM_RD*WORD_W]
// -----------------------------------------------------------------------------
interface id_operand_unit_if
    import id_operand_unit_pkg::*;
#(
    parameter int WORD_W    = WORD_W_DEF,
    parameter int REG_IDX_W = REG_IDX_W_DEF,
    parameter int NUM_RD    = NUM_RD_DEF,
    parameter int NUM_FWD   = NUM_FWD_DEF
);

    logic                           i_valid;
    logic [NUM_RD-1:0]              i_rd_en;
    logic [NUM_RD*REG_IDX_W-1:0]    i_rd_reg;
    logic [NUM_RD*WORD_W-1:0]       i_rf_data;
    logic [NUM_FWD-1:0]             i_fwd_valid;
    logic [NUM_FWD*REG_IDX_W-1:0]   i_fwd_reg;
    logic [NUM_FWD*WORD_W-1:0]      i_fwd_data;
    logic                           i_is_load;
    logic [REG_IDX_W-1:0]           i_dest_reg;
    logic                           o_stall;
    logic                           o_valid;
    logic [NUM_RD*WORD_W-1:0]       o_data;

    modport master (
        output i_valid, i_rd_en, i_rd_reg, i_rf_data,
               i_fwd_valid, i_fwd_reg, i_fwd_data, i_is_load, i_dest_reg,
        input  o_stall, o_valid, o_data
    );

    modport slave (
        input  i_valid, i_rd_en, i_rd_reg, i_rf_data,
               i_fwd_valid, i_fwd_reg, i_fwd_data, i_is_load, i_dest_reg,
        output o_stall, o_valid, o_data
    );

endinterface

// File: rtl/id_operand_unit_fwd_mux.sv
// -----------------------------------------------------------------------------
// id_fwd_mux
// Combinational priority forwarding mux for one source operand.
// Ports:
//   i_reg        source register index
//   i_en         operand is a register (otherwise the result is zero)
//   i_rf_data    register-file read data for this operand
//   i_fwd_valid  per forwarding source: writes a register this cycle
//   i_fwd_reg    packed forwarding destinations
//   i_fwd_data   packed forwarding data
//   o_data       resolved operand word
// Source 0 is the youngest producer and wins over older ones.
// -----------------------------------------------------------------------------
module id_fwd_mux
    import id_operand_unit_pkg::*;
#(
    parameter int WORD_W    = WORD_W_DEF,
    parameter int REG_IDX_W = REG_IDX_W_DEF,
    parameter int NUM_FWD   = NUM_FWD_DEF
) (
    input  logic [REG_IDX_W-1:0]         i_reg,
    input  logic                         i_en,
    input  logic [WORD_W-1:0]            i_rf_data,
    input  logic [NUM_FWD-1:0]           i_fwd_valid,
    input  logic [NUM_FWD*REG_IDX_W-1:0] i_fwd_reg,
    input  logic [NUM_FWD*WORD_W-1:0]    i_fwd_data,
    output logic [WORD_W-1:0]            o_data
);

    op_src_e             w_src;
    logic [WORD_W-1:0]   w_fwd_word;

    always_comb begin
        w_src      = OP_RF;
        w_fwd_word = '0;
        // Scan oldest to youngest so the lowest matching index is the last
        // assignment and therefore wins.
        for (int f = NUM_FWD - 1; f >= 0; f--) begin
            if (i_fwd_valid[f] && (i_fwd_reg[f*REG_IDX_W +: REG_IDX_W] == i_reg)) begin
                w_src      = OP_FWD;
                w_fwd_word = i_fwd_data[f*WORD_W +: WORD_W];
            end
        end
        // x0 reads and non-register operands are zero; this also keeps a
        // producer that "writes" x0 from ever matching.
        if (!i_en || (i_reg == '0)) begin
            w_src = OP_ZERO;
        end
    end

    always_comb begin
        case (w_src)
            OP_FWD:  o_data = w_fwd_word;
            OP_RF:   o_data = i_rf_data;
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/id_operand_unit.sv
// -----------------------------------------------------------------------------
// id_operand_unit
// Decode-stage operand resolution: each of NUM_RD source operands is resolved
// through a priority forwarding network (falling back to register-file data),
// a per-register load-latency scoreboard detects load-use hazards that cannot
// be forwarded yet and raises a combinational stall, and accepted operands are
// registered for execute one cycle later.
// Ports:
//   clk   clock
//   clr   synchronous active-high reset / flush
//   bus   id_operand_unit_if.slave (request inputs, o_stall/o_valid/o_data)
// LOAD_LAT must lie in 1..7 (scoreboard counter width is 3 bits).
// -----------------------------------------------------------------------------
module id_operand_unit
    import id_operand_unit_pkg::*;
#(
    parameter int WORD_W    = WORD_W_DEF,
    parameter int REG_IDX_W = REG_IDX_W_DEF,
    parameter int NUM_RD    = NUM_RD_DEF,
    parameter int NUM_FWD   = NUM_FWD_DEF,
    parameter int LOAD_LAT  = LOAD_LAT_DEF
) (
    input logic              clk,
    input logic              clr,
    id_operand_unit_if.slave bus
);

    localparam int                  NUM_REGS = 1 << REG_IDX_W;
    localparam logic [SB_CNT_W-1:0] LAT_CNT  = SB_CNT_W'(LOAD_LAT);

    logic [SB_CNT_W-1:0]        r_sb_cnt [NUM_REGS];
    logic                       w_hazard;
    logic                       w_stall;
    logic                       w_accept;
    logic                       w_load_issue;
    logic [NUM_RD*WORD_W-1:0]   w_operand;
    logic                       r_vld_p1;
    logic [NUM_RD*WORD_W-1:0]   r_data_p1;

    // ---- p0: decode-cycle resolution and hazard detection ----
    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        id_fwd_mux #(
            .WORD_W    (WORD_W),
            .REG_IDX_W (REG_IDX_W),
            .NUM_FWD   (NUM_FWD)
        ) u_fwd_mux (
            .i_reg       (bus.i_rd_reg[p*REG_IDX_W +: REG_IDX_W]),
            .i_en        (bus.i_rd_en[p]),
            .i_rf_data   (bus.i_rf_data[p*WORD_W +: WORD_W]),
            .i_fwd_valid (bus.i_fwd_valid),
            .i_fwd_reg   (bus.i_fwd_reg),
            .i_fwd_data  (bus.i_fwd_data),
            .o_data      (w_operand[p*WORD_W +: WORD_W])
        );
    end

    // Several ports hitting the same busy register still yield one stall;
    // the scoreboard is only read here, never written per port.
    always_comb begin
        w_hazard = 1'b0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (bus.i_rd_en[p]
                && (bus.i_rd_reg[p*REG_IDX_W +: REG_IDX_W] != '0)
                && (r_sb_cnt[bus.i_rd_reg[p*REG_IDX_W +: REG_IDX_W]] != '0)) begin
                w_hazard = 1'b1;
            end
        end
    end

    assign w_stall      = bus.i_valid && w_hazard;
    assign w_accept     = bus.i_valid && !w_stall;
    assign w_load_issue = w_accept && bus.i_is_load && (bus.i_dest_reg != '0);
    assign bus.o_stall  = w_stall;

    // A newly accepted load reloads its counter even if it was about to
    // expire this cycle; a stalled load leaves the scoreboard untouched.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_sb_cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (w_load_issue && (bus.i_dest_reg == REG_IDX_W'(r))) begin
                    r_sb_cnt[r] <= LAT_CNT;
                end else begin
                    r_sb_cnt[r] <= sb_next(r_sb_cnt[r]);
                end
            end
        end
    end

    // ---- p1: operands registered for execute ----
    // A stall or empty slot inserts a bubble; the data register keeps its
    // last accepted value.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_vld_p1  <= 1'b0;
            r_data_p1 <= '0;
        end else begin
            r_vld_p1 <= w_accept;
            if (w_accept) begin
                r_data_p1 <= w_operand;
            end
        end
    end

    assign bus.o_valid = r_vld_p1;
    assign bus.o_data  = r_data_p1;

endmodule

// File: tb/tb_id_operand_unit.sv
module tb_id_operand_unit;

    localparam int WW = 32;
    localparam int RW = 5;
    localparam int NR = 3;
    localparam int NF = 3;
    localparam int LAT_A = 2;
    localparam int LAT_B = 1;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    id_operand_unit_if #(.WORD_W(WW), .REG_IDX_W(RW), .NUM_RD(NR), .NUM_FWD(NF)) bus_a ();
    id_operand_unit_if #(.WORD_W(WW), .REG_IDX_W(RW), .NUM_RD(NR), .NUM_FWD(NF)) bus_b ();

    id_operand_unit #(.WORD_W(WW), .REG_IDX_W(RW), .NUM_RD(NR), .NUM_FWD(NF), .LOAD_LAT(LAT_A))
        dut_a (.clk(clk), .clr(clr), .bus(bus_a));
    id_operand_unit #(.WORD_W(WW), .REG_IDX_W(RW), .NUM_RD(NR), .NUM_FWD(NF), .LOAD_LAT(LAT_B))
        dut_b (.clk(clk), .clr(clr), .bus(bus_b));

    // Stimulus shared by both instances
    logic          v_valid, v_is_load;
    logic [RW-1:0] v_dest;
    logic          v_en    [NR];
    logic [RW-1:0] v_reg   [NR];
    logic [WW-1:0] v_rf    [NR];
    logic          v_fv    [NF];
    logic [RW-1:0] v_freg  [NF];
    logic [WW-1:0] v_fdata [NF];

    // Reference model: a register loaded in cycle c is unavailable through
    // cycle c+LAT; ready_x[r] is the first cycle it may be read again.
    int ready_a [32];
    int ready_b [32];
    int cyc = 0;
    logic exp_stall_a, exp_stall_b, act_stall_a, act_stall_b;
    logic exp_vld_a = 1'b0, exp_vld_b = 1'b0;
    logic [NR*WW-1:0] exp_data_a = '0, exp_data_b = '0;

    int n_pass = 0;
    int n_checks = 0;

    function automatic logic [WW-1:0] ref_operand(input int p);
        if (!v_en[p] || v_reg[p] == '0) return '0;
        for (int f = 0; f < NF; f++)
            if (v_fv[f] && v_freg[f] == v_reg[p]) return v_fdata[f];
        return v_rf[p];
    endfunction

    function automatic logic ref_stall(input bit use_b);
        if (!v_valid) return 1'b0;
        for (int p = 0; p < NR; p++) begin
            if (v_en[p] && v_reg[p] != '0) begin
                if (cyc < (use_b ? ready_b[v_reg[p]] : ready_a[v_reg[p]])) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic clear_inputs();
        clr = 1'b0; v_valid = 1'b0; v_is_load = 1'b0; v_dest = '0;
        for (int p = 0; p < NR; p++) begin v_en[p] = 1'b0; v_reg[p] = '0; v_rf[p] = '0; end
        for (int f = 0; f < NF; f++) begin v_fv[f] = 1'b0; v_freg[f] = '0; v_fdata[f] = '0; end
    endtask

    // Applies the current stimulus for one clock, samples the stall before
    // the edge and advances the model across the edge.
    task automatic step();
        logic [NR*WW-1:0] ops;
        logic acc_a, acc_b;
        bus_a.i_valid = v_valid;  bus_b.i_valid = v_valid;
        bus_a.i_is_load = v_is_load; bus_b.i_is_load = v_is_load;
        bus_a.i_dest_reg = v_dest; bus_b.i_dest_reg = v_dest;
        for (int p = 0; p < NR; p++) begin
            bus_a.i_rd_en[p] = v_en[p];                 bus_b.i_rd_en[p] = v_en[p];
            bus_a.i_rd_reg[p*RW +: RW] = v_reg[p];      bus_b.i_rd_reg[p*RW +: RW] = v_reg[p];
            bus_a.i_rf_data[p*WW +: WW] = v_rf[p];      bus_b.i_rf_data[p*WW +: WW] = v_rf[p];
        end
        for (int f = 0; f < NF; f++) begin
            bus_a.i_fwd_valid[f] = v_fv[f];             bus_b.i_fwd_valid[f] = v_fv[f];
            bus_a.i_fwd_reg[f*RW +: RW] = v_freg[f];    bus_b.i_fwd_reg[f*RW +: RW] = v_freg[f];
            bus_a.i_fwd_data[f*WW +: WW] = v_fdata[f];  bus_b.i_fwd_data[f*WW +: WW] = v_fdata[f];
        end
        #1;
        exp_stall_a = ref_stall(1'b0);
        exp_stall_b = ref_stall(1'b1);
        act_stall_a = bus_a.o_stall;
        act_stall_b = bus_b.o_stall;
        for (int p = 0; p < NR; p++) ops[p*WW +: WW] = ref_operand(p);
        @(posedge clk);
        if (clr) begin
            for (int r = 0; r < 32; r++) begin ready_a[r] = 0; ready_b[r] = 0; end
            exp_vld_a = 1'b0; exp_vld_b = 1'b0; exp_data_a = '0; exp_data_b = '0;
        end else begin
            acc_a = v_valid && !exp_stall_a;
            acc_b = v_valid && !exp_stall_b;
            exp_vld_a = acc_a;
            exp_vld_b = acc_b;
            if (acc_a) exp_data_a = ops;
            if (acc_b) exp_data_b = ops;
            if (acc_a && v_is_load && v_dest != '0) ready_a[v_dest] = cyc + 1 + LAT_A;
            if (acc_b && v_is_load && v_dest != '0) ready_b[v_dest] = cyc + 1 + LAT_B;
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        clr = 1'b1; v_valid = 1'b1; v_en[0] = 1'b1; v_reg[0] = 5'd5; v_rf[0] = 32'h77;
        step();
        n_checks++;
        if (bus_a.o_valid !== 1'b0 || bus_b.o_valid !== 1'b0)
            $display("FAIL reset_valid: got a=%b b=%b, want 0", bus_a.o_valid, bus_b.o_valid);
        else n_pass++;
        n_checks++;
        if (bus_a.o_data !== '0 || bus_b.o_data !== '0)
            $display("FAIL reset_data: got a=%h b=%h, want 0", bus_a.o_data, bus_b.o_data);
        else n_pass++;
        clr = 1'b0;
        step();
        n_checks++;
        if (act_stall_a !== 1'b0 || act_stall_b !== 1'b0)
            $display("FAIL reset_stall: got a=%b b=%b, want 0", act_stall_a, act_stall_b);
        else n_pass++;
        n_checks++;
        if (bus_a.o_valid !== 1'b1 || bus_a.o_data[0 +: WW] !== 32'h77)
            $display("FAIL reset_first_accept: got vld=%b d0=%h, want 1/00000077", bus_a.o_valid, bus_a.o_data[0 +: WW]);
        else n_pass++;
    endtask

    task automatic test_forwarding();
        clear_inputs();
        v_valid = 1'b1;
        v_en[0] = 1'b1; v_reg[0] = 5'd5; v_rf[0] = 32'h11;
        v_en[1] = 1'b1; v_reg[1] = 5'd9; v_rf[1] = 32'h33;
        v_rf[2] = 32'h44;
        v_fv[2] = 1'b1; v_freg[2] = 5'd5; v_fdata[2] = 32'h22;
        step();
        n_checks++;
        if (bus_a.o_data[0 +: WW] !== 32'h22)
            $display("FAIL fwd_port0: got %h, want 00000022", bus_a.o_data[0 +: WW]);
        else n_pass++;
        n_checks++;
        if (bus_a.o_data !== {32'h0, 32'h33, 32'h22} || bus_a.o_data !== exp_data_a)
            $display("FAIL fwd_all_ports: got %h, want %h", bus_a.o_data, {32'h0, 32'h33, 32'h22});
        else n_pass++;
    endtask

    task automatic test_priority_x0();
        clear_inputs();
        v_valid = 1'b1;
        v_en[0] = 1'b1; v_reg[0] = 5'd7; v_rf[0] = 32'h99;
        v_fv[0] = 1'b1; v_freg[0] = 5'd7; v_fdata[0] = 32'hA;
        v_fv[1] = 1'b1; v_freg[1] = 5'd7; v_fdata[1] = 32'hB;
        step();
        n_checks++;
        if (bus_a.o_data[0 +: WW] !== 32'hA)
            $display("FAIL fwd_priority: got %h, want 0000000a", bus_a.o_data[0 +: WW]);
        else n_pass++;
        v_reg[0] = 5'd0; v_rf[0] = 32'h55;
        v_freg[0] = 5'd0; v_fdata[0] = 32'hFF;
        v_en[1] = 1'b1; v_reg[1] = 5'd12; v_rf[1] = 32'h66;
        v_freg[1] = 5'd12; v_fdata[1] = 32'hB;
        v_fv[2] = 1'b1; v_freg[2] = 5'd12; v_fdata[2] = 32'hC;
        step();
        n_checks++;
        if (bus_a.o_data[0 +: WW] !== 32'h0)
            $display("FAIL x0_read: got %h, want 00000000", bus_a.o_data[0 +: WW]);
        else n_pass++;
        n_checks++;
        if (bus_b.o_data[WW +: WW] !== 32'hB)
            $display("FAIL fwd_priority_port1: got %h, want 0000000b", bus_b.o_data[WW +: WW]);
        else n_pass++;
    endtask

    // Issues a load to `dest`, then holds a reader of `rdreg` on the given
    // ports for three cycles, checking stall and valid sequences.
    task automatic test_load_use();
        logic sa [3] = '{1'b1, 1'b1, 1'b0};
        logic sb [3] = '{1'b1, 1'b0, 1'b0};
        logic va [3] = '{1'b0, 1'b0, 1'b1};
        clear_inputs();
        v_valid = 1'b1; v_is_load = 1'b1; v_dest = 5'd3;
        v_en[0] = 1'b1; v_reg[0] = 5'd1; v_rf[0] = 32'h5;
        step();
        n_checks++;
        if (bus_a.o_valid !== 1'b1)
            $display("FAIL load_accept: got vld=%b, want 1", bus_a.o_valid);
        else n_pass++;
        v_is_load = 1'b0; v_dest = '0; v_reg[0] = 5'd3; v_rf[0] = 32'h123;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (act_stall_a !== sa[i] || act_stall_a !== exp_stall_a)
                $display("FAIL load_use_stall_a[%0d]: got %b, want %b", i, act_stall_a, sa[i]);
            else n_pass++;
            n_checks++;
            if (act_stall_b !== sb[i] || act_stall_b !== exp_stall_b)
                $display("FAIL load_use_stall_b[%0d]: got %b, want %b", i, act_stall_b, sb[i]);
            else n_pass++;
            n_checks++;
            if (bus_a.o_valid !== va[i])
                $display("FAIL load_use_bubble[%0d]: got vld=%b, want %b", i, bus_a.o_valid, va[i]);
            else n_pass++;
        end
        n_checks++;
        if (bus_a.o_data[0 +: WW] !== 32'h123)
            $display("FAIL load_use_data: got %h, want 00000123", bus_a.o_data[0 +: WW]);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic sa [3] = '{1'b1, 1'b1, 1'b0};
        clear_inputs();
        v_valid = 1'b1; v_is_load = 1'b1; v_dest = 5'd3;
        step();
        v_valid = 1'b0;
        step();
        // counter on x3 is at its last busy cycle here; reload it
        v_valid = 1'b1;
        step();
        n_checks++;
        if (act_stall_a !== 1'b0 || bus_a.o_valid !== 1'b1)
            $display("FAIL reload_accept: got stall=%b vld=%b, want 0/1", act_stall_a, bus_a.o_valid);
        else n_pass++;
        v_is_load = 1'b0; v_dest = '0;
        v_en[1] = 1'b1; v_reg[1] = 5'd3; v_rf[1] = 32'hBEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (act_stall_a !== sa[i] || act_stall_a !== exp_stall_a)
                $display("FAIL reload_stall_a[%0d]: got %b, want %b", i, act_stall_a, sa[i]);
            else n_pass++;
            n_checks++;
            if (act_stall_b !== exp_stall_b)
                $display("FAIL reload_stall_b[%0d]: got %b, want %b", i, act_stall_b, exp_stall_b);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_hazard();
        clear_inputs();
        v_valid = 1'b1; v_is_load = 1'b1; v_dest = 5'd6;
        step();
        v_dest = 5'd7;
        step();
        v_is_load = 1'b0; v_dest = '0;
        v_en[0] = 1'b1; v_reg[0] = 5'd6; v_rf[0] = 32'h600;
        v_en[1] = 1'b1; v_reg[1] = 5'd7; v_rf[1] = 32'h700;
        clr = 1'b1;
        step();
        n_checks++;
        if (act_stall_a !== 1'b1)
            $display("FAIL mid_hazard_stall: got %b, want 1", act_stall_a);
        else n_pass++;
        n_checks++;
        if (bus_a.o_valid !== 1'b0 || bus_a.o_data !== '0)
            $display("FAIL mid_hazard_clear: got vld=%b data=%h, want 0/0", bus_a.o_valid, bus_a.o_data);
        else n_pass++;
        clr = 1'b0;
        step();
        n_checks++;
        if (act_stall_a !== 1'b0 || act_stall_b !== 1'b0)
            $display("FAIL post_clear_stall: got a=%b b=%b, want 0", act_stall_a, act_stall_b);
        else n_pass++;
        n_checks++;
        if (bus_a.o_valid !== 1'b1 || bus_a.o_data !== {32'h0, 32'h700, 32'h600})
            $display("FAIL post_clear_data: got vld=%b data=%h, want 1/%h", bus_a.o_valid, bus_a.o_data, {32'h0, 32'h700, 32'h600});
        else n_pass++;
    endtask

    task automatic test_dual_port_busy();
        logic sa [3] = '{1'b1, 1'b1, 1'b0};
        logic sb [3] = '{1'b1, 1'b0, 1'b0};
        clear_inputs();
        v_valid = 1'b1; v_is_load = 1'b1; v_dest = 5'd4;
        step();
        v_is_load = 1'b0; v_dest = '0;
        v_en[0] = 1'b1; v_reg[0] = 5'd4; v_rf[0] = 32'h40;
        v_en[1] = 1'b1; v_reg[1] = 5'd8; v_rf[1] = 32'h80;
        v_en[2] = 1'b1; v_reg[2] = 5'd4; v_rf[2] = 32'h41;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (act_stall_a !== sa[i] || act_stall_b !== sb[i])
                $display("FAIL dual_port_stall[%0d]: got a=%b b=%b, want a=%b b=%b", i, act_stall_a, act_stall_b, sa[i], sb[i]);
            else n_pass++;
        end
        n_checks++;
        if (bus_a.o_valid !== 1'b1 || bus_a.o_data !== {32'h41, 32'h80, 32'h40})
            $display("FAIL dual_port_data: got vld=%b data=%h, want 1/%h", bus_a.o_valid, bus_a.o_data, {32'h41, 32'h80, 32'h40});
        else n_pass++;
    endtask

    task automatic test_random();
        clear_inputs();
        for (int n = 0; n < 400; n++) begin
            clr = ($urandom_range(0, 39) == 0);
            v_valid = ($urandom_range(0, 3) != 0);
            v_is_load = ($urandom_range(0, 2) == 0);
            v_dest = RW'($urandom_range(0, 7));
            for (int p = 0; p < NR; p++) begin
                v_en[p] = $urandom_range(0, 1) == 1;
                v_reg[p] = RW'($urandom_range(0, 7));
                v_rf[p] = $urandom;
            end
            for (int f = 0; f < NF; f++) begin
                v_fv[f] = $urandom_range(0, 1) == 1;
                v_freg[f] = RW'($urandom_range(0, 7));
                v_fdata[f] = $urandom;
            end
            step();
            n_checks++;
            if (act_stall_a !== exp_stall_a || act_stall_b !== exp_stall_b)
                $display("FAIL rand_stall[%0d]: got a=%b b=%b, want a=%b b=%b", n, act_stall_a, act_stall_b, exp_stall_a, exp_stall_b);
            else n_pass++;
            n_checks++;
            if (bus_a.o_valid !== exp_vld_a || bus_b.o_valid !== exp_vld_b)
                $display("FAIL rand_valid[%0d]: got a=%b b=%b, want a=%b b=%b", n, bus_a.o_valid, bus_b.o_valid, exp_vld_a, exp_vld_b);
            else n_pass++;
            n_checks++;
            if (bus_a.o_data !== exp_data_a)
                $display("FAIL rand_data_a[%0d]: got %h, want %h", n, bus_a.o_data, exp_data_a);
            else n_pass++;
            n_checks++;
            if (bus_b.o_data !== exp_data_b)
                $display("FAIL rand_data_b[%0d]: got %h, want %h", n, bus_b.o_data, exp_data_b);
            else n_pass++;
        end
        clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_priority_x0();
        test_load_use();
        test_simultaneous();
        test_reset_mid_hazard();
        test_dual_port_busy();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
